// File: rtl/pipe_mem_arb.sv
`timescale 1ns/1ps
// pipe_mem_arb: arbitrates fetch (IF) and load/store (LS) requests onto one memory port.
// Latency: request accepted in IDLE, mem_req_valid_o one cycle later; response passed through combinationally.
// Backpressure: one transaction outstanding; req_ready_o only in IDLE; response ready follows the owner's ready.
// Ports:
//   clk_i, rst_i (sync, active-high), flush_i
//   if_req_* / if_rsp_*   fetch request/response handshakes
//   ls_req_* / ls_rsp_*   load/store request/response handshakes
//   mem_req_* / mem_rsp_* shared memory port (request fields registered)
module pipe_mem_arb #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        if_req_valid_i,
  output logic        if_req_ready_o,
  input  logic [31:0] if_req_addr_i,
  output logic        if_rsp_valid_o,
  output logic [31:0] if_rsp_data_o,
  input  logic        if_rsp_ready_i,
  input  logic        ls_req_valid_i,
  output logic        ls_req_ready_o,
  input  logic [31:0] ls_req_addr_i,
  input  logic        ls_req_wen_i,
  input  logic [31:0] ls_req_wdata_i,
  input  logic [3:0]  ls_req_wmask_i,
  output logic        ls_rsp_valid_o,
  output logic [31:0] ls_rsp_data_o,
  input  logic        ls_rsp_ready_i,
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output logic [31:0] mem_req_addr_o,
  output logic        mem_req_wen_o,
  output logic [31:0] mem_req_wdata_o,
  output logic [3:0]  mem_req_wmask_o,
  input  logic        mem_rsp_valid_i,
  input  logic [31:0] mem_rsp_data_i,
  output logic        mem_rsp_ready_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP} state_t;

  // Counter must be able to hold STARVE_MAX itself; at least one bit wide.
  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  state_t          state_q, state_d;
  logic            owner_q, owner_d;
  logic            drop_q, drop_d;
  logic [CW-1:0]   starve_q, starve_d;
  logic [31:0]     addr_q, addr_d;
  logic            wen_q, wen_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      wmask_q, wmask_d;
  logic            if_sel;
  logic            rsp_rdy;

  assign mem_req_valid_o = (state_q == S_REQ);
  assign mem_req_addr_o  = addr_q;
  assign mem_req_wen_o   = wen_q;
  assign mem_req_wdata_o = wdata_q;
  assign mem_req_wmask_o = wmask_q;
  assign if_rsp_data_o   = mem_rsp_data_i;
  assign ls_rsp_data_o   = mem_rsp_data_i;
  assign mem_rsp_ready_o = rsp_rdy;

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    drop_d         = drop_q;
    starve_d       = starve_q;
    addr_d         = addr_q;
    wen_d          = wen_q;
    wdata_d        = wdata_q;
    wmask_d        = wmask_q;
    if_req_ready_o = 1'b0;
    ls_req_ready_o = 1'b0;
    if_rsp_valid_o = 1'b0;
    ls_rsp_valid_o = 1'b0;
    rsp_rdy        = 1'b0;
    // IF wins when LS is idle or IF has waited long enough; a flush cycle never grants IF.
    if_sel = if_req_valid_i && !flush_i &&
             (!ls_req_valid_i || (starve_q >= STARVE_LIM));

    unique case (state_q)
      S_IDLE: begin
        drop_d = 1'b0;
        // Grants are suppressed while reset is held so every ready stays low.
        if (!rst_i) begin
          if (if_sel) begin
            if_req_ready_o = 1'b1;
            addr_d   = if_req_addr_i;
            wen_d    = 1'b0;
            wdata_d  = 32'h0;
            wmask_d  = 4'h0;
            owner_d  = OWN_IF;
            starve_d = '0;
            state_d  = S_REQ;
          end else if (ls_req_valid_i) begin
            ls_req_ready_o = 1'b1;
            addr_d   = ls_req_addr_i;
            wen_d    = ls_req_wen_i;
            wdata_d  = ls_req_wdata_i;
            wmask_d  = ls_req_wmask_i;
            owner_d  = OWN_LS;
            if (if_req_valid_i && (starve_q < STARVE_LIM)) begin
              starve_d = starve_q + 1'b1;
            end
            state_d  = S_REQ;
          end
        end
      end

      S_REQ: begin
        // A flushed fetch still goes to memory; only its response is discarded.
        if (flush_i && (owner_q == OWN_IF)) begin
          drop_d = 1'b1;
        end
        if (mem_req_ready_i) begin
          state_d = S_RSP;
        end
      end

      S_RSP: begin
        if (flush_i && (owner_q == OWN_IF)) begin
          drop_d = 1'b1;
        end
        if (drop_q) begin
          rsp_rdy = 1'b1;
        end else if (owner_q == OWN_IF) begin
          if_rsp_valid_o = mem_rsp_valid_i;
          rsp_rdy        = if_rsp_ready_i;
        end else begin
          ls_rsp_valid_o = mem_rsp_valid_i;
          rsp_rdy        = ls_rsp_ready_i;
        end
        if (mem_rsp_valid_i && rsp_rdy) begin
          drop_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      owner_q  <= OWN_IF;
      drop_q   <= 1'b0;
      starve_q <= '0;
      addr_q   <= 32'h0;
      wen_q    <= 1'b0;
      wdata_q  <= 32'h0;
      wmask_q  <= 4'h0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      drop_q   <= drop_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      wen_q    <= wen_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
    end
  end

endmodule

// File: doc/pipe_mem_arb.md
PIPE_MEM_ARB -- requirements
Module: pipe_mem_arb

Interface
REQ-001 Parameter STARVE_MAX, default 4: consecutive LS grants while IF waits before IF is forced to win.
REQ-002 clk_i  in  1  sole clock, all state updates on rising edge.
REQ-003 rst_i  in  1  reset, synchronous, active-high.
REQ-004 flush_i  in  1  pipeline flush; discards in-flight and pending IF traffic.
REQ-005 if_req_valid_i  in  1  fetch request valid.
REQ-006 if_req_ready_o  out  1  fetch request accepted.
REQ-007 if_req_addr_i  in  32  fetch address.
REQ-008 if_rsp_valid_o  out  1  fetch response valid.
REQ-009 if_rsp_data_o  out  32  fetched instruction word.
REQ-010 if_rsp_ready_i  in  1  fetch side accepts response.
REQ-011 ls_req_valid_i  in  1  load/store request valid.
REQ-012 ls_req_ready_o  out  1  load/store request accepted.
REQ-013 ls_req_addr_i  in  32  load/store address.
REQ-014 ls_req_wen_i  in  1  1 = store, 0 = load.
REQ-015 ls_req_wdata_i  in  32  store data.
REQ-016 ls_req_wmask_i  in  4  store byte mask.
REQ-017 ls_rsp_valid_o  out  1  load/store response valid.
REQ-018 ls_rsp_data_o  out  32  load data (don't-care for stores).
REQ-019 ls_rsp_ready_i  in  1  LS side accepts response.
REQ-020 mem_req_valid_o  out  1  request to shared memory port.
REQ-021 mem_req_ready_i  in  1  memory accepts request.
REQ-022 mem_req_addr_o  out  32  registered request address.
REQ-023 mem_req_wen_o  out  1  registered write enable (0 for IF).
REQ-024 mem_req_wdata_o  out  32  registered store data (0 for IF).
REQ-025 mem_req_wmask_o  out  4  registered byte mask (0 for IF).
REQ-026 mem_rsp_valid_i  in  1  memory response valid.
REQ-027 mem_rsp_data_i  in  32  memory response data.
REQ-028 mem_rsp_ready_o  out  1  arbiter accepts memory response.

Function
REQ-029 FSM states IDLE, REQ, RSP; exactly one transaction outstanding; owner register (IF/LS) and drop flag.
REQ-030 IDLE arbitration: LS wins if ls_req_valid_i, unless if_req_valid_i and starve_cnt >= STARVE_MAX, then IF wins; IF not granted in a cycle with flush_i=1.
REQ-031 Winner's req_ready_o = 1 only in IDLE, combinationally, same cycle; loser's req_ready_o = 0; all req_ready_o = 0 outside IDLE.
REQ-032 On accept: latch addr/wen/wdata/wmask (IF: wen/wdata/wmask = 0), record owner, go REQ; mem_req_valid_o rises next cycle (1-cycle request latency).
REQ-033 REQ: mem_req_valid_o = 1, all mem_req_* fields stable until mem_req_ready_i = 1, then go RSP.
REQ-034 RSP, drop = 0: owner rsp_valid_o = mem_rsp_valid_i, rsp_data_o = mem_rsp_data_i, mem_rsp_ready_o = owner rsp_ready_i (combinational); on mem_rsp_valid_i & mem_rsp_ready_o go IDLE; non-owner rsp_valid_o = 0.
REQ-035 flush_i with owner = IF in REQ or RSP sets drop; request never retracted; in RSP with drop: mem_rsp_ready_o = 1, if_rsp_valid_o = 0, go IDLE on mem_rsp_valid_i.
REQ-036 flush_i has no effect on LS-owned transactions; drop clears on return to IDLE.
REQ-037 starve_cnt: +1 (saturating at STARVE_MAX) when LS granted while if_req_valid_i = 1; cleared when IF granted; unchanged otherwise.
REQ-038 STARVE_MAX = 0 gives IF strict priority; no request may be granted in the same cycle the FSM leaves RSP.

Reset
REQ-039 rst_i = 1 at an edge: state IDLE, owner IF, drop 0, starve_cnt 0, latched fields 0; all valid/ready outputs 0 from that edge; an in-flight transaction is abandoned, the response of which the memory side is held in reset with.

Verification
REQ-040 IF only, addr 0x8000_0000, mem ready immediately, rsp 0x0000_0013 one cycle later -> if_req_ready_o cycle 0, mem_req_valid_o cycle 1, if_rsp_data_o = 0x13 cycle 2, back to IDLE.
REQ-041 IF and LS valid continuously, STARVE_MAX = 4 -> grant order LS,LS,LS,LS,IF, repeating.
REQ-042 LS store addr 0x100, wdata 0xDEADBEEF, wmask 0xF, mem_req_ready_i low 3 cycles -> fields stable all 4 cycles, ls_req_ready_o held 0 throughout.
REQ-043 IF request, flush_i pulsed in REQ -> request completes to memory, response consumed with if_rsp_valid_o = 0, next IDLE cycle grants pending LS.
REQ-044 rst_i asserted in RSP -> next cycle all outputs 0, state IDLE, new IF request accepted after reset release.
